// File: rtl/palette_pkg.sv
// Shared constants and state encoding for the palette memory controller.
package palette_pkg;

  localparam int PAL_ADDR_W = 10;
  localparam int PAL_DATA_W = 16;
  localparam int PAL_DEPTH  = 2 ** PAL_ADDR_W;

  // Controller states: idle, bulk clear, write ack, read access, read ack.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WRACK,
    RDWAIT,
    RDACK
  } pal_state_e;

endpackage

// File: rtl/palette_ctrl.sv
// Port-1 arbiter/sequencer for the palette memory: host single-word
// read/write, bulk clear, and optional blank-only host writes. Port 2 is a
// straight pass-through of the pixel lookup address.
module palette_ctrl
  import palette_pkg::*;
#(
  parameter int              ADDR_W        = PAL_ADDR_W,
  parameter int              DATA_W        = PAL_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter bit              BLANK_ONLY_WR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              pix_active,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata1,
  output logic [ADDR_W-1:0] mem_addr2
);

  localparam int CNT_W = ADDR_W + 1;
  // The counter runs one past the last address so the cycle after the final
  // clear write can retire the sequence without a separate flag.
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pal_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr1_q, mem_addr1_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_allowed;

  assign wr_allowed = !BLANK_ONLY_WR || !pix_active;

  // Next-state and next-output logic for the port-1 sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr1_d  = mem_addr1_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d      = CLEAR;
          cnt_d        = '0;
          clear_busy_d = 1'b1;
        end else if (host_req && host_we && wr_allowed) begin
          state_d     = WRACK;
          mem_addr1_d = host_addr;
          mem_wdata_d = host_wdata;
          mem_we_d    = 1'b1;
          host_ack_d  = 1'b1;
        end else if (host_req && !host_we) begin
          state_d     = RDWAIT;
          mem_addr1_d = host_addr;
        end
      end
      WRACK: state_d = IDLE;
      RDWAIT: begin
        // Asynchronous memory: data for mem_addr1 is already on mem_rdata1.
        host_rdata_d = mem_rdata1;
        host_ack_d   = 1'b1;
        state_d      = RDACK;
      end
      RDACK: state_d = IDLE;
      CLEAR: begin
        if (cnt_q == CNT_END) begin
          state_d      = IDLE;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr1_d = cnt_q[ADDR_W-1:0];
          mem_wdata_d = CLEAR_VALUE;
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr1_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      mem_we_q     <= mem_we_d;
      mem_addr1_q  <= mem_addr1_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign mem_we     = mem_we_q;
  assign mem_addr1  = mem_addr1_q;
  assign mem_wdata  = mem_wdata_q;

  // Port 2 is never blocked: pixel lookups bypass the sequencer entirely.
  assign mem_addr2 = pix_addr;

endmodule

// File: tb/tb_palette_ctrl.sv
// Self-checking bench for palette_ctrl: bench-owned async-read palette
// memory, a reference copy of its expected contents, and a read-data
// scoreboard queue filled at request time and drained at host_ack.
module tb_palette_ctrl;
  import palette_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          clear_start, clear_busy, clear_done;
  logic          pix_active;
  logic [AW-1:0] pix_addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] mem_wdata, mem_rdata1;

  always #5 clk = ~clk;

  palette_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_VALUE(16'h0000), .BLANK_ONLY_WR(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .pix_active(pix_active), .pix_addr(pix_addr),
    .mem_we(mem_we), .mem_addr1(mem_addr1), .mem_wdata(mem_wdata),
    .mem_rdata1(mem_rdata1), .mem_addr2(mem_addr2)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i) ^ 16'h5A5A;
  endfunction

  // Palette memory: synchronous write, asynchronous read; 'fill' preloads a
  // recognisable pattern so untouched entries can be told from cleared ones.
  logic [DW-1:0] mem [DEPTH];
  logic          fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      mem[mem_addr1] <= mem_wdata;
    end
  end
  assign mem_rdata1 = mem[mem_addr1];

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance pixel address at the falling edge, check port 2.
  task automatic step();
    @(negedge clk);
    pix_addr = pix_addr + 10'd1;
    #1;
    check("port2", 32'(mem_addr2), 32'(pix_addr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(host_ack),   32'd0);
    check({tag, "_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_busy"},  32'(clear_busy), 32'd0);
    check({tag, "_done"},  32'(clear_done), 32'd0);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_addr1"}, 32'(mem_addr1),  32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      lat++;
      if (host_ack) break;
    end
    if (!host_ack) check("ack_timeout", 32'(host_ack), 32'd1);
  endtask

  task automatic host_read(input logic [AW-1:0] addr, input int exp_lat);
    int lat;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = addr;
    exp_q.push_back(model[addr]);
    wait_ack(64, lat);
    check("rd_lat", 32'(lat), 32'(exp_lat));
    if (exp_q.size() > 0) check("rd_data", 32'(host_rdata), 32'(exp_q.pop_front()));
    host_req = 1'b0;
    step();
    check("rd_ack_pulse", 32'(host_ack), 32'd0);
    check("rd_hold", 32'(host_rdata), 32'(model[addr]));
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int exp_lat);
    int lat;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    wait_ack(64, lat);
    check("wr_lat",   32'(lat),       32'(exp_lat));
    check("wr_we",    32'(mem_we),    32'd1);
    check("wr_addr1", 32'(mem_addr1), 32'(addr));
    check("wr_wdata", 32'(mem_wdata), 32'(data));
    host_req   = 1'b0;
    model[addr] = data;
    step();
    check("wr_we_pulse",  32'(mem_we),   32'd0);
    check("wr_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int lat, cnt;
    rst = 1'b1; fill = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    clear_start = 1'b0; pix_active = 1'b0; pix_addr = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = pat(i);
    step();
    fill = 1'b0;
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full clear: DEPTH ascending writes, then a single clear_done.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("clr_busy_start", 32'(clear_busy), 32'd1);
    check("clr_we_start",   32'(mem_we),     32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      check("clr_we",    32'(mem_we),     32'd1);
      check("clr_addr",  32'(mem_addr1),  32'(k - 1));
      check("clr_wdata", 32'(mem_wdata),  32'h0000);
      check("clr_done0", 32'(clear_done), 32'd0);
      check("clr_busy",  32'(clear_busy), 32'd1);
      model[k-1] = 16'h0000;
    end
    step();
    check("clr_done",     32'(clear_done), 32'd1);
    check("clr_we_end",   32'(mem_we),     32'd0);
    check("clr_busy_end", 32'(clear_busy), 32'd0);
    step();
    check("clr_done_pulse", 32'(clear_done), 32'd0);
    compare_mem("clr_mem");
    host_read(10'h000, 2);
    host_read(10'h3FF, 2);

    // Write then read back.
    host_write(10'h2A5, 16'hBEEF, 1);
    host_read(10'h2A5, 2);

    // Blank gating: write held off during active display.
    pix_active = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_wdata = 16'h1234;
    cnt = 0;
    repeat (50) begin
      step();
      cnt += int'(host_ack);
    end
    check("blank_stall", 32'(cnt), 32'd0);
    pix_active = 1'b0;
    step();
    check("blank_ack", 32'(host_ack), 32'd1);
    check("blank_we",  32'(mem_we),   32'd1);
    host_req = 1'b0;
    model[16] = 16'h1234;
    step();
    check("blank_mem", 32'(mem[16]), 32'h1234);
    pix_active = 1'b1;
    host_read(10'h010, 2);
    pix_active = 1'b0;

    // Collision: clear wins, host write completes after clear_done.
    clear_start = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h005; host_wdata = 16'hAAAA;
    step();
    clear_start = 1'b0;
    lat = 1;
    cnt = 0;
    check("coll_busy", 32'(clear_busy), 32'd1);
    check("coll_noack", 32'(host_ack), 32'd0);
    for (int c = 0; c < 2000; c++) begin
      step();
      lat++;
      cnt += int'(clear_done);
      if (host_ack) break;
    end
    check("coll_ack", 32'(host_ack), 32'd1);
    check("coll_lat", 32'(lat), 32'd1027);
    check("coll_done_cnt", 32'(cnt), 32'd1);
    host_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    model[5] = 16'hAAAA;
    step();
    compare_mem("coll_mem");

    // Reset mid-clear: abort after address 299 has been issued.
    fill = 1'b1;
    step();
    fill = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = pat(i);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (300) step();
    check("mid_we",   32'(mem_we),    32'd1);
    check("mid_addr", 32'(mem_addr1), 32'd299);
    rst = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      step();
      cnt += int'(clear_done);
    end
    check("mid_no_done", 32'(cnt), 32'd0);
    for (int i = 0; i < 300; i++) model[i] = 16'h0000;
    compare_mem("mid_mem");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/palette_ctrl.md
Name: palette_ctrl

Overview:
- Sequencing and sharing controller in front of the 1024x16 palette memory in pipeline stage 4.
- Owns memory port 1 (read/write) and shares it between the host register interface (single-word read/write) and a bulk-clear sequencer.
- Passes the pixel pipeline's lookup address straight to read port 2.
- Optionally holds host writes off until blanking, to avoid mid-frame palette tearing.

Parameters:
- ADDR_W, 10, palette address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 16, palette entry width.
- CLEAR_VALUE, 16'h0000, word written to every entry by a bulk clear.
- BLANK_ONLY_WR, 1, 1 = host writes stall while pix_active=1; 0 = host writes are accepted at any time.

Ports:
- clk  in  1  single design clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- host_req  in  1  host access request; held high until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req=1.
- host_addr  in  ADDR_W  host palette index.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  read data, valid in the host_ack cycle of a read.
- clear_start  in  1  pulse: start a bulk clear.
- clear_busy  out  1  high while a clear is running.
- clear_done  out  1  one-cycle pulse after the last clear write.
- pix_active  in  1  high during the active display region.
- pix_addr  in  ADDR_W  pixel lookup index.
- mem_we  out  1  port-1 write enable to the palette memory.
- mem_addr1  out  ADDR_W  port-1 address.
- mem_wdata  out  DATA_W  port-1 write data.
- mem_rdata1  in  DATA_W  port-1 asynchronous read data.
- mem_addr2  out  ADDR_W  port-2 address; combinational copy of pix_addr.

Behaviour:
Reset:
- rst=1 at a rising edge: state=IDLE, clear counter=0, and host_ack, host_rdata, clear_busy, clear_done, mem_we, mem_addr1, mem_wdata all 0.
- Reset mid-clear aborts the clear: no clear_done pulse, and entries not yet written are left as they were.
- mem_addr2 = pix_addr at all times, including during reset.

State machine (state register IDLE, CLEAR, WRACK, RDWAIT, RDACK; all outputs except mem_addr2 are registered):
- IDLE, priority order:
  1. clear_start=1 -> CLEAR; counter=0, clear_busy=1.
  2. host_req=1, host_we=1, and (BLANK_ONLY_WR=0 or pix_active=0) -> WRACK; load mem_addr1=host_addr, mem_wdata=host_wdata, mem_we=1, host_ack=1.
  3. host_req=1, host_we=0 -> RDWAIT; load mem_addr1=host_addr. Reads are never blank-gated.
  4. Otherwise stay in IDLE with mem_we=0.
- WRACK: the write commits at the end of this cycle. Next edge: mem_we=0, host_ack=0, -> IDLE.
- RDWAIT: mem_rdata1 is valid (asynchronous memory). Capture it into host_rdata, set host_ack=1, -> RDACK.
- RDACK: host_ack=0; host_rdata holds its value until the next read. -> IDLE.
- CLEAR:
  - Each cycle: mem_we=1, mem_addr1=counter, mem_wdata=CLEAR_VALUE, counter increments.
  - The clear write loop issues exactly DEPTH writes, covering addresses 0..DEPTH-1 in ascending order.
  - After the edge that issues address DEPTH-1: -> IDLE with mem_we=0, clear_busy=0, clear_done=1 for one cycle.
  - The counter saturates and does not wrap.
  - Clear ignores pix_active.

Latency:
- Write: req seen at edge N; mem_we and host_ack high in cycle N+1; the next request can be accepted at edge N+2.
- Read: req seen at edge N; host_ack and host_rdata valid in cycle N+2.
- Clear: DEPTH+1 cycles from the clear_start edge to clear_done.

Boundary conditions:
- clear_start and host_req asserted in the same IDLE cycle: clear wins; the host stalls (no ack) until clear_done, then is served.
- clear_start while not in IDLE (CLEAR, WRACK, RDWAIT, RDACK): ignored, not queued.
- A pending write while pix_active=1 (BLANK_ONLY_WR=1): no ack; the write is accepted on the first IDLE edge with pix_active=0.
- host_req dropped before host_ack: the request is abandoned. This is a protocol violation; the bench flags it.
- Port 2 is never blocked by any state.

Decomposition:
- Package palette_pkg: ADDR_W/DATA_W defaults, DEPTH constant, and the state enum (IDLE, CLEAR, WRACK, RDWAIT, RDACK).
- Single module; no sub-module is warranted. The clear counter is local.

Test Plan:
- Reset then clear: pulse clear_start -> mem_we=1 for 1024 consecutive cycles covering addresses 0..1023 with data 0x0000; clear_done pulses exactly once at cycle 1025; host reads of 0x000, 0x3FF return 0x0000.
- Write then read: write 0x2A5 <= 0xBEEF with pix_active=0 -> host_ack at N+1, mem_we for exactly one cycle; read 0x2A5 -> host_ack at N+2 with host_rdata=0xBEEF.
- Blank gating: BLANK_ONLY_WR=1, pix_active=1, write 0x010 <= 0x1234 -> no ack for 50 cycles; drop pix_active -> ack 1 cycle after the next edge and the memory holds 0x1234. A read issued under pix_active=1 is acked at N+2.
- Collision: clear_start and host write 0x005 <= 0xAAAA in the same cycle -> clear runs first, then the write completes; entry 0x005 = 0xAAAA and all other entries = 0.
- Reset mid-clear: assert rst at counter=300 -> all outputs 0 next cycle, no clear_done, entries 0..299 cleared and entry 300 upward unchanged.
- Port 2: sweep pix_addr 0..1023 during a clear and a host read -> mem_addr2 equals pix_addr every cycle.
